// File: rtl/ledz_pkg.sv
// Shared constants, RGB565 field positions, address helpers and the loader FSM
// state type for the LED panel framebuffer path.
package ledz_pkg;

  localparam int unsigned FRAME_WORDS = 2048;
  localparam int unsigned HALF_WORDS  = 1024;

  localparam int unsigned HALF_AW = 10;
  localparam int unsigned WR_AW   = 12;

  localparam int unsigned RGB_R_MSB = 15;
  localparam int unsigned RGB_R_LSB = 11;
  localparam int unsigned RGB_G_MSB = 10;
  localparam int unsigned RGB_G_LSB = 5;
  localparam int unsigned RGB_B_MSB = 4;
  localparam int unsigned RGB_B_LSB = 0;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DRAIN,
    PEND_SWAP
  } state_e;

  // Buffer index on top, then half select and word-within-half.
  function automatic logic [WR_AW-1:0] fb_addr(input logic buf_idx,
                                               input logic [HALF_AW:0] idx);
    return {buf_idx, idx};
  endfunction

endpackage

// File: rtl/spi_frame_loader_sync_edge.sv
// Multi-flop synchronizer with registered rise/fall pulses (spi_sync_edge).
// RST_VAL lets a line come out of reset looking already asserted.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/spi_frame_loader.sv
// SPI RGB565 frame receiver writing into the panel framebuffer, single clock.
// Define LEDZ_DOUBLE_BUFFER_EN for double buffering with scan-aligned swaps.
module spi_frame_loader
  import ledz_pkg::*;
#(
  parameter int unsigned WORDS_PER_FRAME = FRAME_WORDS,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_sclk,
  input  logic             spi_mosi,
  input  logic             spi_cs,
  input  logic             scan_wrap,
  output logic             wr_en,
  output logic [WR_AW-1:0] wr_addr,
  output logic [15:0]      wr_data,
  output logic             disp_buf,
  output logic             frame_done,
  output logic             overrun,
  output logic             busy
);

  localparam logic [WR_AW-1:0] WPF_W = WR_AW'(WORDS_PER_FRAME);

  logic sclk_rise, sclk_s_unused, sclk_fall_unused;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (spi_sclk),
    .q    (sclk_s_unused),
    .rise (sclk_rise),
    .fall (sclk_fall_unused)
  );

  // CS syncs reset high so a window already open across reset yields no rise.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (spi_cs),
    .q    (cs_s),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mosi_sync_q <= '0;
    else     mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  state_e           state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [WR_AW-1:0] word_idx_q, word_idx_d;
  logic [15:0]      shift_q, shift_d;
  logic             word_done_q, word_done_d;
  logic             fall_pend_q, fall_pend_d;
  logic             wr_en_q, wr_en_d;
  logic [WR_AW-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]      wr_data_q, wr_data_d;
  logic             frame_done_q, frame_done_d;
  logic             overrun_q, overrun_d;
  logic             back;
  logic             word_wrap;

`ifdef LEDZ_DOUBLE_BUFFER_EN
  logic disp_buf_q, disp_buf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) disp_buf_q <= 1'b0;
    else     disp_buf_q <= disp_buf_d;
  end
  assign back     = ~disp_buf_q;
  assign disp_buf = disp_buf_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{scan_wrap, cs_s};
  assign back       = 1'b0;
  assign disp_buf   = 1'b0;
`endif

  assign word_wrap = sclk_rise && (bit_cnt_q == 4'hF);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    word_idx_d   = word_idx_q;
    shift_d      = shift_q;
    word_done_d  = 1'b0;
    fall_pend_d  = fall_pend_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
`ifdef LEDZ_DOUBLE_BUFFER_EN
    disp_buf_d   = disp_buf_q;
`endif

    case (state_q)
      IDLE: begin
        if (cs_rise) begin
          state_d     = RECV;
          bit_cnt_d   = '0;
          word_idx_d  = '0;
          fall_pend_d = 1'b0;
        end
      end

      RECV: begin
        if (sclk_rise) begin
          shift_d   = {shift_q[14:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'hF) word_done_d = 1'b1;
        end

        if (word_done_q) begin
          if (word_idx_q < WPF_W) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = fb_addr(back, word_idx_q[HALF_AW:0]);
            wr_data_d  = shift_q;
            word_idx_d = word_idx_q + 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end

        // A CS fall racing a completing word is held until that word is written.
        if (cs_fall || fall_pend_q) begin
          if (word_done_q || word_wrap) begin
            fall_pend_d = 1'b1;
          end else begin
            fall_pend_d = 1'b0;
            state_d     = IDLE;
            if (word_idx_q == WPF_W) begin
`ifdef LEDZ_DOUBLE_BUFFER_EN
              state_d      = PEND_SWAP;
`else
              frame_done_d = 1'b1;
`endif
            end
          end
        end
      end

`ifdef LEDZ_DOUBLE_BUFFER_EN
      PEND_SWAP: begin
        if (cs_s) overrun_d = 1'b1;
        if (scan_wrap) begin
          disp_buf_d   = ~disp_buf_q;
          frame_done_d = 1'b1;
          state_d      = cs_s ? DRAIN : IDLE;
        end
      end

      DRAIN: begin
        if (!cs_s) state_d = IDLE;
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      word_idx_q   <= '0;
      shift_q      <= '0;
      word_done_q  <= 1'b0;
      fall_pend_q  <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      word_idx_q   <= word_idx_d;
      shift_q      <= shift_d;
      word_done_q  <= word_done_d;
      fall_pend_q  <= fall_pend_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_spi_frame_loader.sv
// Self-checking bench for spi_frame_loader with a scaled frame size; honours
// LEDZ_DOUBLE_BUFFER_EN when it is defined for the build.
module tb_spi_frame_loader;

  localparam int WPF  = 16;
  localparam int SS   = 2;
  localparam int HALF = SS + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sclk, spi_mosi, spi_cs, scan_wrap;
  logic        wr_en, disp_buf, frame_done, overrun, busy;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;

  spi_frame_loader #(.WORDS_PER_FRAME(WPF), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_cs     (spi_cs),
    .scan_wrap  (scan_wrap),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .disp_buf   (disp_buf),
    .frame_done (frame_done),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int last_e0 = 0;
  int fd_cnt = 0;
  int fd0 = 0;
  int spacing_bad = 0;
  logic prev_wr = 1'b0;
  logic disp_m = 1'b0;
  logic [27:0] obs_q[$];
  logic [15:0] sent_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      obs_q.push_back({wr_addr, wr_data});
      last_wr_cyc = cyc;
      if (prev_wr) spacing_bad++;
    end
    prev_wr = wr_en;
    if (frame_done) fd_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic back_m();
`ifdef LEDZ_DOUBLE_BUFFER_EN
    return ~disp_m;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: first min(n, WPF) words land at buffer*2048 + index, in order.
  task automatic check_writes(input string tag, input logic bb, input int n_sent);
    int n_exp;
    logic [11:0] ea;
    n_exp = (n_sent < WPF) ? n_sent : WPF;
    check({tag, "_count"}, obs_q.size(), n_exp);
    for (int k = 0; k < n_exp && k < obs_q.size(); k++) begin
      ea = (bb ? 12'd2048 : 12'd0) + 12'(k);
      check(tag, obs_q[k], {ea, sent_q[k]});
    end
  endtask

  task automatic sclk_bit(input logic b, input logic drop_cs);
    @(negedge clk);
    spi_mosi = b;
    spi_sclk = 1'b1;
    if (drop_cs) spi_cs = 1'b0;
    last_e0 = cyc + 1;
    repeat (HALF) @(negedge clk);
    spi_sclk = 1'b0;
    repeat (HALF - 1) @(negedge clk);
  endtask

  task automatic send_word(input logic [15:0] w, input logic drop_last);
    for (int i = 15; i >= 0; i--) sclk_bit(w[i], drop_last && (i == 0));
    sent_q.push_back(w);
  endtask

  task automatic cs_up();
    @(negedge clk);
    spi_cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_down();
    @(negedge clk);
    spi_cs = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic start_txn();
    obs_q.delete();
    sent_q.delete();
    fd0 = fd_cnt;
    cs_up();
  endtask

  task automatic pulse_wrap();
    @(negedge clk);
    scan_wrap = 1'b1;
    @(negedge clk);
    scan_wrap = 1'b0;
  endtask

  initial begin
    rst = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_cs = 1'b0; scan_wrap = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addr_data", {wr_addr, wr_data}, 0);
    check("rst_flags", {wr_en, disp_buf, frame_done, overrun, busy}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("post_rst_flags", {wr_en, disp_buf, frame_done, overrun, busy}, 0);

    // Full frame, word n = n
    start_txn();
    check("recv_busy", busy, 1);
    for (int n = 0; n < WPF; n++) send_word(16'(n), 1'b0);
    check("full_latency", last_wr_cyc - last_e0, SS + 2);
    check("full_ovr_hold", overrun, 0);
    cs_down();
    check_writes("full", back_m(), WPF);
    check("full_ovr", overrun, 0);
`ifdef LEDZ_DOUBLE_BUFFER_EN
    check("pend_busy", busy, 1);
    check("pend_no_fd", fd_cnt - fd0, 0);
    check("pend_disp", disp_buf, 0);
    pulse_wrap();
    check("swap_fd_pulse", frame_done, 1);
    check("swap_disp", disp_buf, 1);
    disp_m = 1'b1;
    repeat (3) @(negedge clk);
    check("swap_fd_count", fd_cnt - fd0, 1);
    check("swap_idle", busy, 0);
`else
    check("full_fd", fd_cnt - fd0, 1);
    check("full_idle", busy, 0);
    pulse_wrap();
    repeat (3) @(negedge clk);
    check("wrap_ignored_disp", disp_buf, 0);
    check("wrap_ignored_fd", fd_cnt - fd0, 1);
`endif

    // Short frame
    start_txn();
    for (int n = 0; n < 5; n++) send_word(16'($urandom), 1'b0);
    cs_down();
    check_writes("short", back_m(), 5);
    check("short_fd", fd_cnt - fd0, 0);
    check("short_disp", disp_buf, disp_m);
    check("short_ovr", overrun, 0);
    check("short_idle", busy, 0);

    // Partial trailing word discarded
    start_txn();
    send_word(16'hF800, 1'b0);
    for (int i = 0; i < 7; i++) sclk_bit(1'($urandom), 1'b0);
    cs_down();
    check_writes("partial", back_m(), 1);
    check("partial_fd", fd_cnt - fd0, 0);
    check("partial_idle", busy, 0);

    // CS fall coincident with last SCLK rise
    start_txn();
    send_word(16'($urandom), 1'b0);
    send_word(16'($urandom), 1'b1);
    repeat (12) @(negedge clk);
    check_writes("csfall_last", back_m(), 2);
    check("csfall_idle", busy, 0);
    check("csfall_fd", fd_cnt - fd0, 0);

`ifdef LEDZ_DOUBLE_BUFFER_EN
    // New transaction while a swap is pending
    start_txn();
    for (int n = 0; n < WPF; n++) send_word(16'($urandom), 1'b0);
    cs_down();
    check_writes("pend_frame", back_m(), WPF);
    obs_q.delete();
    cs_up();
    send_word(16'($urandom), 1'b0);
    send_word(16'($urandom), 1'b0);
    check("pend_no_writes", obs_q.size(), 0);
    check("pend_ovr", overrun, 1);
    pulse_wrap();
    check("pend_swap_disp", disp_buf, ~disp_m);
    disp_m = ~disp_m;
    repeat (2) @(negedge clk);
    check("drain_busy", busy, 1);
    cs_down();
    check("drain_idle", busy, 0);
    start_txn();
    for (int n = 0; n < 3; n++) send_word(16'($urandom), 1'b0);
    cs_down();
    check_writes("after_pend", back_m(), 3);
`endif

    // Reset mid-transaction
    start_txn();
    for (int n = 0; n < 3; n++) send_word(16'($urandom), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rstmid_flags", {wr_en, disp_buf, frame_done, overrun, busy}, 0);
    rst = 1'b0;
    disp_m = 1'b0;
    obs_q.delete();
    for (int n = 0; n < 3; n++) send_word(16'($urandom), 1'b0);
    check("rstmid_no_writes", obs_q.size(), 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_outs", {wr_addr, wr_data}, 0);
    check("rstmid_flags2", {disp_buf, frame_done, overrun}, 0);
    cs_down();
    start_txn();
    for (int n = 0; n < 2; n++) send_word(16'($urandom), 1'b0);
    cs_down();
    check_writes("rstmid_next", back_m(), 2);

    // Too-long frame
    start_txn();
    for (int n = 0; n < WPF; n++) send_word(16'($urandom), 1'b0);
    check("long_ovr_before", overrun, 0);
    send_word(16'($urandom), 1'b0);
    check("long_ovr_after", overrun, 1);
    send_word(16'($urandom), 1'b0);
    cs_down();
    check_writes("long", back_m(), WPF + 2);
`ifdef LEDZ_DOUBLE_BUFFER_EN
    pulse_wrap();
    repeat (2) @(negedge clk);
    check("long_disp", disp_buf, ~disp_m);
`else
    check("long_fd", fd_cnt - fd0, 1);
`endif
    check("long_ovr_sticky", overrun, 1);
    check("wr_spacing", spacing_bad, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
